// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg -- shared definitions for the configurable flip-flop bank.
//   mode_t : 2-bit flip-flop type selector shared by ff_bank and ff_cell
//            (MODE_SR, MODE_JK, MODE_D, MODE_T).
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

endpackage

// File: rtl/ff_cell.sv
// ff_cell -- one flip-flop channel of the bank.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   en         : clock enable; the channel holds when low
//   mode       : flip-flop type (SR, JK, D, T)
//   a, b       : S/J/D/T and R/K inputs
//   q          : registered state
//   ill        : registered flag, high for one cycle after an illegal SR edge
//   ill_now    : combinational "this edge is illegal" indication for the top
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  mode_t mode,
  input  logic  a,
  input  logic  b,
  output logic  q,
  output logic  ill,
  output logic  ill_now
);

  logic q_next_s;

  // Next-state and illegal-input decode for the selected flip-flop type.
  always_comb begin
    q_next_s = q;
    ill_now  = 1'b0;
    if (en) begin
      case (mode)
        MODE_SR: begin
          // S=R=1 is illegal: state holds and the event is flagged.
          if (a & b) begin
            ill_now = 1'b1;
          end else if (a) begin
            q_next_s = 1'b1;
          end else if (b) begin
            q_next_s = 1'b0;
          end else begin
            q_next_s = q;
          end
        end
        MODE_JK: begin
          if (a & b) begin
            q_next_s = ~q;
          end else if (a) begin
            q_next_s = 1'b1;
          end else if (b) begin
            q_next_s = 1'b0;
          end else begin
            q_next_s = q;
          end
        end
        MODE_D:  q_next_s = a;
        MODE_T:  q_next_s = q ^ a;
        default: q_next_s = q;
      endcase
    end else begin
      q_next_s = q;
      ill_now  = 1'b0;
    end
  end

  // State register and one-cycle illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= RESET_BIT;
      ill <= 1'b0;
    end else begin
      q   <= q_next_s;
      ill <= ill_now;
    end
  end

endmodule

// File: rtl/ff_bank.sv
// ff_bank -- WIDTH independent SR/JK/D/T flip-flops sharing one mode select,
// with per-channel illegal-input flags, a sticky error flag and, when the
// macro FF_BANK_ERRCNT_EN is defined, a saturating illegal-cycle counter.
// Ports:
//   CLK, RST_N : clock (rising edge) and asynchronous active-low reset
//   MODE       : 00 SR, 01 JK, 10 D, 11 T for all channels
//   EN         : clock enable
//   A, B       : per-channel S/J/D/T and R/K inputs
//   Q, QB      : registered state and its complement
//   ILL        : per-channel one-cycle illegal flag
//   ERR        : sticky illegal flag, cleared by ERR_CLR
//   ERR_CLR    : synchronous clear of ERR (and ERR_CNT)
//   ERR_CNT    : saturating count of illegal cycles (FF_BANK_ERRCNT_EN only)
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       MODE,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic [WIDTH-1:0] ILL,
  output logic             ERR,
  input  logic             ERR_CLR
`ifdef FF_BANK_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] ERR_CNT
`endif
);

  mode_t            mode_s;
  logic [WIDTH-1:0] ill_now_s;
  logic             ill_any_s;
  logic             err_r;

  assign mode_s    = mode_t'(MODE);
  assign ill_any_s = |ill_now_s;

  // QB is derived from Q so it tracks reset without its own register.
  assign QB  = ~Q;
  assign ERR = err_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk     (CLK),
      .rst_n   (RST_N),
      .en      (EN),
      .mode    (mode_s),
      .a       (A[i]),
      .b       (B[i]),
      .q       (Q[i]),
      .ill     (ILL[i]),
      .ill_now (ill_now_s[i])
    );
  end

  // Sticky error flag; a new illegal event wins over a clear on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_r <= 1'b0;
    end else if (ill_any_s) begin
      err_r <= 1'b1;
    end else if (ERR_CLR) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

`ifdef FF_BANK_ERRCNT_EN
  logic [CNT_W-1:0] cnt_r;

  assign ERR_CNT = cnt_r;

  // Saturating illegal-cycle counter; clear plus event restarts at one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (ill_any_s) begin
      if (ERR_CLR) begin
        cnt_r <= CNT_W'(1);
      end else if (cnt_r != {CNT_W{1'b1}}) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (ERR_CLR) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank -- randomized scoreboard bench for ff_bank (WIDTH=8,
// RESET_VAL=8'hA5, CNT_W=2). Driver pushes reference-model expectations,
// a monitor pops and compares one per clock.
module tb_ff_bank;

  localparam int         WIDTH   = 8;
  localparam logic [7:0] RV      = 8'hA5;
  localparam int         CNT_W   = 2;
  localparam int         CNT_MAX = 3;

  typedef struct {
    logic [7:0] q;
    logic [7:0] ill;
    logic       err;
    int         cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       en;
  logic [7:0] a, b;
  logic [7:0] q, qb, ill;
  logic       err;
  logic       err_clr;
`ifdef FF_BANK_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  exp_t q_exp[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state
  logic [7:0] m_q;
  logic       m_err;
  int         m_cnt;

  ff_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RV),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .MODE    (mode),
    .EN      (en),
    .A       (a),
    .B       (b),
    .Q       (q),
    .QB      (qb),
    .ILL     (ill),
    .ERR     (err),
    .ERR_CLR (err_clr)
`ifdef FF_BANK_ERRCNT_EN
    ,
    .ERR_CNT (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model: applies the flip-flop rules channel by channel.
  task automatic model_step(input logic e, input logic [1:0] m, input logic [7:0] aa,
                            input logic [7:0] bb, input logic c, output exp_t x);
    logic [7:0] ill_n;
    ill_n = 8'h00;
    if (e) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (m)
          2'd0: begin
            if (aa[i] && bb[i]) ill_n[i] = 1'b1;
            else if (aa[i])     m_q[i] = 1'b1;
            else if (bb[i])     m_q[i] = 1'b0;
          end
          2'd1: begin
            if (aa[i] && bb[i]) m_q[i] = !m_q[i];
            else if (aa[i])     m_q[i] = 1'b1;
            else if (bb[i])     m_q[i] = 1'b0;
          end
          2'd2:    m_q[i] = aa[i];
          default: if (aa[i]) m_q[i] = !m_q[i];
        endcase
      end
    end
    if (ill_n != 8'h00) begin
      m_err = 1'b1;
      if (c) m_cnt = 1;
      else if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (c) begin
      m_err = 1'b0;
      m_cnt = 0;
    end
    x.q   = m_q;
    x.ill = ill_n;
    x.err = m_err;
    x.cnt = m_cnt;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] aa,
                       input logic [7:0] bb, input logic c);
    exp_t x;
    @(negedge clk);
    #1;
    en = e; mode = m; a = aa; b = bb; err_clr = c;
    model_step(e, m, aa, bb, c, x);
    q_exp.push_back(x);
  endtask

  // Asynchronous reset asserted between clock edges, checked with no edge.
  task automatic do_reset();
    logic [7:0] rvb;
    rvb = ~RV;
    @(negedge clk);
    #2;
    en = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("RST_Q", q, RV);
    chk("RST_QB", qb, rvb);
    chk("RST_ILL", ill, 8'h00);
    chk("RST_ERR", err, 1'b0);
`ifdef FF_BANK_ERRCNT_EN
    chk("RST_CNT", err_cnt, 0);
`endif
    q_exp.delete();
    m_q = RV; m_err = 1'b0; m_cnt = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per clock once the scoreboard holds one.
  always @(negedge clk) begin
    exp_t x;
    logic [7:0] eqb;
    if (q_exp.size() > 0) begin
      x   = q_exp.pop_front();
      eqb = ~x.q;
      chk("Q", q, x.q);
      chk("QB", qb, eqb);
      chk("ILL", ill, x.ill);
      chk("ERR", err, x.err);
`ifdef FF_BANK_ERRCNT_EN
      chk("ERR_CNT", err_cnt, x.cnt);
`endif
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00; err_clr = 1'b0;
    m_q = RV; m_err = 1'b0; m_cnt = 0;
    do_reset();

    // directed scenarios
    drive(1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0);   // SR -> 0F
    drive(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);   // SR illegal on ch0
    drive(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);   // ILL drops, ERR stays
    drive(1'b1, 2'd2, 8'h00, 8'h00, 1'b0);   // D -> 00
    drive(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);   // JK toggle -> FF
    drive(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);   // JK toggle -> 00
    repeat (4) drive(1'b1, 2'd3, 8'h03, 8'($urandom), 1'b0);
    repeat (2) drive(1'b0, 2'd3, 8'h03, 8'hFF, 1'b0);   // frozen
    drive(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);   // disabled SR 11: no ILL
    do_reset();
    repeat (5) drive(1'b1, 2'd0, 8'h81, 8'h81, 1'b0);  // counter saturates
    drive(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b1);   // clear + illegal: set wins
    drive(1'b1, 2'd2, 8'h5A, 8'h00, 1'b1);   // clear alone
    drive(1'b1, 2'd2, 8'hC3, 8'h00, 1'b0);

    // randomized traffic with occasional mid-run resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 4) != 0), 2'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 7) == 0));
      end
    end

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && q_exp.size() > 0; k++) @(negedge clk);
    #1;
    n_chk++;
    if (q_exp.size() != 0) begin
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
